ddr_in_deser: RTL and testbench

- DDR input capture and deserializer; the receive-side counterpart of the team's DDR output cell.
- Samples a DATA_W-bit pin bus on both edges of clk: rising edge first, then falling.
- Realigns each rise/fall pair into the posedge domain and frames pairs into words using a sync strobe.
- Presents completed words on a valid/ready interface to fabric logic such as the bus/video capture path.

---
 rtl/ddr_pkg.sv | 17 +
 rtl/ddr_in_capture.sv | 43 ++++
 rtl/ddr_in_deser.sv | 106 ++++++++++
 tb/tb_ddr_in_deser.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types and helpers for the DDR input deserializer.
// Holds the framing FSM state type and the beat-counter width helper.
package ddr_pkg;

  typedef enum logic {
    HUNT     = 1'b0,
    ASSEMBLE = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ddr_in_capture.sv
// DDR pin capture: rise/fall halves registered on both clock edges
// and presented as one posedge-domain pair.
module ddr_in_capture
  import ddr_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic [DATA_W-1:0]   din,
  input  logic                sync,
  output logic                pair_valid,
  output logic                pair_sync,
  output logic [2*DATA_W-1:0] pair_data
);

  logic [DATA_W-1:0] r_rise;
  logic [DATA_W-1:0] r_fall;
  logic              r_sync;
  logic              r_ce;

  always_ff @(posedge clk) begin
    r_rise <= din;
    if (reset) begin
      r_ce   <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_ce   <= ce;
      r_sync <= sync;
    end
  end

  // r_ce here is the enable sampled at the preceding posedge
  always_ff @(negedge clk) begin
    if (r_ce) r_fall <= din;
  end

  assign pair_valid = r_ce;
  assign pair_sync  = r_sync;
  assign pair_data  = {r_fall, r_rise};

endmodule

// File: rtl/ddr_in_deser.sv
// DDR input deserializer: frames captured rise/fall pairs into words
// using a sync strobe and offers them on a single-slot valid/ready port.
module ddr_in_deser
  import ddr_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int BEATS  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [DATA_W-1:0]         din,
  input  logic                      sync,
  output logic [2*DATA_W*BEATS-1:0] out_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow,
  output logic                      resync_err
);

  localparam int CW = clog2(BEATS);
  localparam int PW = 2 * DATA_W;
  localparam int WW = PW * BEATS;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic          w_pv;
  logic          w_ps;
  logic [PW-1:0] w_pd;

  ddr_in_capture #(
    .DATA_W(DATA_W)
  ) u_cap (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .din       (din),
    .sync      (sync),
    .pair_valid(w_pv),
    .pair_sync (w_ps),
    .pair_data (w_pd)
  );

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [WW-1:0] r_buf;
  logic [WW-1:0] r_word;
  logic          r_valid;
  logic          r_ovf;
  logic          r_rerr;

  logic          w_store;
  logic          w_done;
  logic          w_mid;
  logic [CW-1:0] w_idx;
  logic [WW-1:0] w_word;

  always_comb begin
    w_store = w_pv && (w_ps || (r_state == ASSEMBLE));
    w_idx   = w_ps ? '0 : r_cnt;
    w_done  = w_store && (w_idx == LAST);
    w_mid   = w_pv && w_ps && (r_state == ASSEMBLE)
              && (r_cnt != '0);
    w_word  = r_buf;
    w_word[int'(w_idx)*PW +: PW] = w_pd;
  end

  // Stale upper beats after a resync are overwritten before completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HUNT;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else if (w_store) begin
      r_state <= ASSEMBLE;
      r_buf   <= w_word;
      r_cnt   <= w_done ? '0 : w_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_rerr  <= 1'b0;
    end else begin
      if (w_mid) r_rerr <= 1'b1;
      if (w_done) begin
        if (!r_valid || out_ready) begin
          r_word  <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_word   = r_word;
  assign out_valid  = r_valid;
  assign overflow   = r_ovf;
  assign resync_err = r_rerr;

endmodule

// File: tb/tb_ddr_in_deser.sv
// Directed bench for ddr_in_deser (DATA_W=4, BEATS=2).
// Each task drives one scenario and checks against hand-computed words.
module tb_ddr_in_deser;

  logic        clk;
  logic        reset;
  logic        ce;
  logic [3:0]  din;
  logic        sync;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        resync_err;

  int total;
  int bad;

  ddr_in_deser #(
    .DATA_W(4),
    .BEATS (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .din       (din),
    .sync      (sync),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .resync_err(resync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rise half set up before posedge, fall half before negedge
  task automatic beat(input logic [3:0] r, input logic [3:0] f,
                      input logic s, input logic c);
    din  = r;
    sync = s;
    ce   = c;
    @(posedge clk);
    #2;
    din  = f;
    sync = 1'b0;
    @(negedge clk);
    #2;
  endtask

  task automatic tick();
    din  = 4'h0;
    sync = 1'b0;
    ce   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din   = 4'h0;
    sync  = 1'b0;
    ce    = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    do_reset();
    total++;
    if (out_word !== 16'h0) begin
      bad++;
      $display("FAIL reset_word got=%h want=0000", out_word);
    end
    total++;
    if ({out_valid, overflow, resync_err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000",
               {out_valid, overflow, resync_err});
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    beat(4'hA, 4'hB, 1'b1, 1'b1);
    beat(4'hC, 4'hD, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early got=%b want=0", out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_word !== 16'hDCBA) begin
      bad++;
      $display("FAIL basic_word got=%b/%h want=1/dcba",
               out_valid, out_word);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse got=%b want=0", out_valid);
    end
  endtask

  task automatic test_freerun();
    beat(4'h1, 4'h2, 1'b0, 1'b1);
    beat(4'h3, 4'h4, 1'b0, 1'b1);
    beat(4'h5, 4'h6, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_word !== 16'h4321) begin
      bad++;
      $display("FAIL free_w0 got=%b/%h want=1/4321",
               out_valid, out_word);
    end
    beat(4'h7, 4'h8, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL free_gap got=%b want=0", out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_word !== 16'h8765) begin
      bad++;
      $display("FAIL free_w1 got=%b/%h want=1/8765",
               out_valid, out_word);
    end
    total++;
    if (resync_err !== 1'b0) begin
      bad++;
      $display("FAIL free_rerr got=%b want=0", resync_err);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL free_drain got=%b want=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    beat(4'h9, 4'hA, 1'b0, 1'b1);
    beat(4'hB, 4'hC, 1'b0, 1'b1);
    beat(4'h1, 4'h2, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_word !== 16'hCBA9) begin
      bad++;
      $display("FAIL bp_first got=%b/%h want=1/cba9",
               out_valid, out_word);
    end
    beat(4'h3, 4'h4, 1'b0, 1'b1);
    tick();
    total++;
    if (out_valid !== 1'b1 || out_word !== 16'hCBA9) begin
      bad++;
      $display("FAIL bp_hold got=%b/%h want=1/cba9",
               out_valid, out_word);
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_ovf got=%b want=1", overflow);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_word !== 16'hCBA9) begin
      bad++;
      $display("FAIL bp_accept got=%b/%h want=0/cba9",
               out_valid, out_word);
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_sticky got=%b want=1", overflow);
    end
  endtask

  task automatic test_resync();
    do_reset();
    beat(4'h1, 4'h2, 1'b1, 1'b1);
    beat(4'h3, 4'h4, 1'b1, 1'b1);
    beat(4'h5, 4'h6, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0 || resync_err !== 1'b1) begin
      bad++;
      $display("FAIL rs_mid got=%b/%b want=0/1",
               out_valid, resync_err);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_word !== 16'h6543) begin
      bad++;
      $display("FAIL rs_word got=%b/%h want=1/6543",
               out_valid, out_word);
    end
    tick();
  endtask

  task automatic test_ce_gate();
    beat(4'h1, 4'h2, 1'b1, 1'b1);
    beat(4'hE, 4'hE, 1'b1, 1'b0);
    beat(4'hF, 4'hF, 1'b0, 1'b0);
    beat(4'hF, 4'hF, 1'b0, 1'b0);
    beat(4'h3, 4'h4, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ce_early got=%b want=0", out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_word !== 16'h4321) begin
      bad++;
      $display("FAIL ce_word got=%b/%h want=1/4321",
               out_valid, out_word);
    end
    tick();
  endtask

  task automatic test_reset_hunt();
    int seen;
    beat(4'h1, 4'h2, 1'b1, 1'b1);
    do_reset();
    total++;
    if ({out_valid, overflow, resync_err} !== 3'b000
        || out_word !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%h want=000/0000",
               {out_valid, overflow, resync_err}, out_word);
    end
    seen = 0;
    beat(4'h3, 4'h4, 1'b0, 1'b1);
    if (out_valid === 1'b1) seen++;
    beat(4'h5, 4'h6, 1'b0, 1'b1);
    if (out_valid === 1'b1) seen++;
    beat(4'h7, 4'h8, 1'b0, 1'b1);
    if (out_valid === 1'b1) seen++;
    tick();
    if (out_valid === 1'b1) seen++;
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL hunt_ignore got=%0d want=0", seen);
    end
    beat(4'h9, 4'hA, 1'b1, 1'b1);
    beat(4'hB, 4'hC, 1'b0, 1'b1);
    tick();
    total++;
    if (out_valid !== 1'b1 || out_word !== 16'hCBA9) begin
      bad++;
      $display("FAIL hunt_word got=%b/%h want=1/cba9",
               out_valid, out_word);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    ce        = 1'b0;
    din       = 4'h0;
    sync      = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_freerun();
    test_back_to_back();
    test_resync();
    test_ce_gate();
    test_reset_hunt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
